// File: rtl/asfifo_wrarb.sv
// ============================================================================
// asfifo_wrarb : async-FIFO write side - 2-way round-robin arbiter, RAM write
//                sequencing, Gray write pointer, synchronised full/level.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module asfifo_wrarb #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          ack1,
  output logic          fifo_we,
  output logic [AW-1:0] fifo_waddr,
  output logic [DW-1:0] fifo_wdata,
  output logic [AW:0]   wptr_gray,
  input  logic [AW:0]   rptr_gray,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0] C_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_rs1;
  logic [AW:0] r_rs2;
  logic [AW:0] r_wbin;
  logic        r_last;     // 1: requester 1 had the last grant
  logic [AW:0] w_rbin_s;
  logic        w_full;
  logic        w_ack0;
  logic        w_ack1;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else begin
      r_rs1 <= rptr_gray;
      r_rs2 <= r_rs1;
    end
  end

  always_comb begin
    w_rbin_s = gray2bin(r_rs2);
    w_full   = (r_wbin[AW] != w_rbin_s[AW]) && (r_wbin[AW-1:0] == w_rbin_s[AW-1:0]);
    w_ack0   = rst_n && !w_full && req0 && (!req1 || r_last);
    w_ack1   = rst_n && !w_full && req1 && (!req0 || !r_last);
  end

  assign full  = w_full;
  assign level = r_wbin - w_rbin_s;
  assign ack0  = w_ack0;
  assign ack1  = w_ack1;

  // wptr_gray tracks wbin one cycle late, so it only moves once the RAM write has landed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin     <= '0;
      r_last     <= 1'b1;
      fifo_we    <= 1'b0;
      fifo_waddr <= '0;
      fifo_wdata <= '0;
      wptr_gray  <= '0;
    end else begin
      wptr_gray <= r_wbin ^ (r_wbin >> 1);
      if (w_ack0 || w_ack1) begin
        fifo_we    <= 1'b1;
        fifo_waddr <= r_wbin[AW-1:0];
        fifo_wdata <= w_ack1 ? data1 : data0;
        r_wbin     <= r_wbin + C_ONE;
        r_last     <= w_ack1;
      end else begin
        fifo_we <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
